// File: rtl/checkpoint_seq_monitor.sv
// Checkpoint-sequence monitor: confirms that up to DEPTH masked codes appear on chk_in in order,
// each within a cycle budget. Define CHECKPOINT_SEQ_MONITOR_ORDER_CHECK_EN to flag out-of-order steps.
module checkpoint_seq_monitor #(
  parameter int CHK_W         = 16,
  parameter int DEPTH         = 8,
  parameter int IDX_W         = 3,
  parameter int TIMEOUT_W     = 24,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [CHK_W-1:0]     chk_in,
  input  logic                 load_en,
  input  logic [IDX_W-1:0]     load_idx,
  input  logic [CHK_W-1:0]     load_code,
  input  logic [CHK_W-1:0]     load_mask,
  input  logic [IDX_W:0]       num_steps,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic [1:0]           fail_reason,
  output logic [IDX_W:0]       step_idx,
  output logic                 match_pulse
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  localparam logic [1:0] RSN_NONE  = 2'b00;
  localparam logic [1:0] RSN_TOUT  = 2'b01;
  localparam logic [1:0] RSN_ORDER = 2'b10;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0]     STABLE_TGT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]     ONE_CNT    = CNT_W'(1);
  localparam logic [IDX_W:0]       DEPTH_V    = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]       ONE_IDX    = (IDX_W+1)'(1);
  localparam logic [TIMEOUT_W-1:0] ONE_TMR    = TIMEOUT_W'(1);

  logic [1:0]           state_r;
  logic [CHK_W-1:0]     code_r [DEPTH];
  logic [CHK_W-1:0]     mask_r [DEPTH];
  logic [IDX_W:0]       steps_r;
  logic [TIMEOUT_W-1:0] tout_r;
  logic [TIMEOUT_W-1:0] timer_r;
  logic [CNT_W-1:0]     stable_r;

  logic [IDX_W-1:0]     cur_slot_s;
  logic                 cur_match_s;
  logic [CNT_W-1:0]     stable_inc_s;
  logic                 accept_s;
  logic [IDX_W:0]       step_next_s;
  logic [TIMEOUT_W-1:0] timer_inc_s;
  logic                 timeout_s;
  logic [IDX_W:0]       arm_steps_s;
  logic                 ooo_hit_s;

  // Current-step compare, saturating counters, timeout detect and step-count clamp
  always_comb begin
    cur_slot_s  = step_idx[IDX_W-1:0];
    cur_match_s = (((chk_in ^ code_r[cur_slot_s]) & mask_r[cur_slot_s]) == {CHK_W{1'b0}});
    if (stable_r == {CNT_W{1'b1}}) begin
      stable_inc_s = stable_r;
    end else begin
      stable_inc_s = stable_r + ONE_CNT;
    end
    accept_s    = cur_match_s && (stable_inc_s == STABLE_TGT);
    step_next_s = step_idx + ONE_IDX;
    if (timer_r == {TIMEOUT_W{1'b1}}) begin
      timer_inc_s = timer_r;
    end else begin
      timer_inc_s = timer_r + ONE_TMR;
    end
    timeout_s = (tout_r != {TIMEOUT_W{1'b0}}) && (timer_r == (tout_r - ONE_TMR)) && !accept_s;
    if (num_steps > DEPTH_V) begin
      arm_steps_s = DEPTH_V;
    end else begin
      arm_steps_s = num_steps;
    end
  end

`ifdef CHECKPOINT_SEQ_MONITOR_ORDER_CHECK_EN
  logic [CNT_W-1:0] ooo_r;
  logic [CNT_W-1:0] ooo_inc_s;
  logic             ooo_any_s;

  // Detect a later active step's code on the bus while the current one is absent
  always_comb begin
    ooo_any_s = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (((IDX_W+1)'(j) > step_idx) && ((IDX_W+1)'(j) < steps_r) &&
          (((chk_in ^ code_r[j]) & mask_r[j]) == {CHK_W{1'b0}})) begin
        ooo_any_s = 1'b1;
      end else begin
        ooo_any_s = ooo_any_s;
      end
    end
    if (ooo_r == {CNT_W{1'b1}}) begin
      ooo_inc_s = ooo_r;
    end else begin
      ooo_inc_s = ooo_r + ONE_CNT;
    end
    ooo_hit_s = ooo_any_s && !cur_match_s && (ooo_inc_s == STABLE_TGT);
  end

  // Out-of-order streak counter; only live on RUN edges that neither accept nor time out
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ooo_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_RUN) && !abort && !accept_s && !timeout_s &&
                 ooo_any_s && !cur_match_s) begin
      ooo_r <= ooo_inc_s;
    end else begin
      ooo_r <= {CNT_W{1'b0}};
    end
  end
`else
  // Order checking not built: no out-of-order verdict can occur
  always_comb begin
    ooo_hit_s = 1'b0;
  end
`endif

  // Sequence table, FSM and registered verdict outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r     <= ST_IDLE;
      steps_r     <= {(IDX_W+1){1'b0}};
      tout_r      <= {TIMEOUT_W{1'b0}};
      timer_r     <= {TIMEOUT_W{1'b0}};
      stable_r    <= {CNT_W{1'b0}};
      busy        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_reason <= RSN_NONE;
      step_idx    <= {(IDX_W+1){1'b0}};
      match_pulse <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        code_r[i] <= {CHK_W{1'b0}};
        mask_r[i] <= {CHK_W{1'b1}};
      end
    end else begin
      match_pulse <= 1'b0;
      if (load_en && !busy) begin
        code_r[load_idx] <= load_code;
        mask_r[load_idx] <= load_mask;
      end
      if (abort) begin
        state_r     <= ST_IDLE;
        busy        <= 1'b0;
        pass        <= 1'b0;
        fail        <= 1'b0;
        fail_reason <= RSN_NONE;
      end else begin
        case (state_r)
          ST_RUN: begin
            if (accept_s) begin
              match_pulse <= 1'b1;
              step_idx    <= step_next_s;
              stable_r    <= {CNT_W{1'b0}};
              timer_r     <= {TIMEOUT_W{1'b0}};
              if (step_next_s == steps_r) begin
                state_r <= ST_PASS;
                busy    <= 1'b0;
                pass    <= 1'b1;
              end
            end else if (timeout_s) begin
              state_r     <= ST_FAIL;
              busy        <= 1'b0;
              fail        <= 1'b1;
              fail_reason <= RSN_TOUT;
            end else if (ooo_hit_s) begin
              state_r     <= ST_FAIL;
              busy        <= 1'b0;
              fail        <= 1'b1;
              fail_reason <= RSN_ORDER;
            end else begin
              timer_r  <= timer_inc_s;
              stable_r <= cur_match_s ? stable_inc_s : {CNT_W{1'b0}};
            end
          end
          ST_IDLE, ST_PASS, ST_FAIL: begin
            if (start) begin
              steps_r     <= arm_steps_s;
              tout_r      <= timeout_cycles;
              timer_r     <= {TIMEOUT_W{1'b0}};
              stable_r    <= {CNT_W{1'b0}};
              fail        <= 1'b0;
              fail_reason <= RSN_NONE;
              step_idx    <= {(IDX_W+1){1'b0}};
              // An empty sequence is an immediate pass and never shows busy
              if (arm_steps_s == {(IDX_W+1){1'b0}}) begin
                state_r <= ST_PASS;
                busy    <= 1'b0;
                pass    <= 1'b1;
              end else begin
                state_r <= ST_RUN;
                busy    <= 1'b1;
                pass    <= 1'b0;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Self-checking bench for checkpoint_seq_monitor: directed scenarios plus randomized traffic,
// every cycle compared against a sequence-level reference model.
module tb_checkpoint_seq_monitor;
  localparam int CHK_W         = 16;
  localparam int DEPTH         = 8;
  localparam int IDX_W         = 3;
  localparam int TIMEOUT_W     = 24;
  localparam int STABLE_CYCLES = 2;

  logic                 wb_clk_i = 1'b0;
  logic                 wb_rst_i;
  logic [CHK_W-1:0]     chk_in;
  logic                 load_en;
  logic [IDX_W-1:0]     load_idx;
  logic [CHK_W-1:0]     load_code;
  logic [CHK_W-1:0]     load_mask;
  logic [IDX_W:0]       num_steps;
  logic [TIMEOUT_W-1:0] timeout_cycles;
  logic                 start;
  logic                 abort;
  logic                 busy;
  logic                 pass;
  logic                 fail;
  logic [1:0]           fail_reason;
  logic [IDX_W:0]       step_idx;
  logic                 match_pulse;

  always #5 wb_clk_i = ~wb_clk_i;

  checkpoint_seq_monitor #(
    .CHK_W(CHK_W), .DEPTH(DEPTH), .IDX_W(IDX_W),
    .TIMEOUT_W(TIMEOUT_W), .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .chk_in(chk_in),
    .load_en(load_en), .load_idx(load_idx), .load_code(load_code), .load_mask(load_mask),
    .num_steps(num_steps), .timeout_cycles(timeout_cycles), .start(start), .abort(abort),
    .busy(busy), .pass(pass), .fail(fail), .fail_reason(fail_reason),
    .step_idx(step_idx), .match_pulse(match_pulse)
  );

  int checks   = 0;
  int failures = 0;
  int n_pulses = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: sequence-level view (running flag, step number, match streak, cycles spent)
  logic [CHK_W-1:0] m_code [DEPTH];
  logic [CHK_W-1:0] m_mask [DEPTH];
  bit m_busy, m_pass, m_fail, m_pulse;
  int m_reason, m_step, m_steps, m_tout, m_streak, m_wait, m_ooo;

  function automatic bit hits(input logic [CHK_W-1:0] v, input int i);
    return ((v ^ m_code[i]) & m_mask[i]) == 16'h0000;
  endfunction

  task automatic model_edge();
    bit cur, later;
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_code[i] = 16'h0000;
        m_mask[i] = 16'hFFFF;
      end
      m_busy = 0; m_pass = 0; m_fail = 0; m_pulse = 0;
      m_reason = 0; m_step = 0; m_steps = 0; m_tout = 0;
      m_streak = 0; m_wait = 0; m_ooo = 0;
      return;
    end
    m_pulse = 0;
    cur = m_busy ? hits(chk_in, m_step) : 1'b0;
    later = 1'b0;
    for (int j = m_step + 1; j < m_steps; j++) begin
      if (hits(chk_in, j)) later = 1'b1;
    end
    if (load_en && !m_busy) begin
      m_code[load_idx] = load_code;
      m_mask[load_idx] = load_mask;
    end
    if (abort) begin
      m_busy = 0; m_pass = 0; m_fail = 0; m_reason = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_steps = (int'(num_steps) > DEPTH) ? DEPTH : int'(num_steps);
        m_tout = int'(timeout_cycles);
        m_fail = 0; m_reason = 0; m_step = 0;
        m_streak = 0; m_wait = 0; m_ooo = 0;
        m_pass = (m_steps == 0);
        m_busy = (m_steps != 0);
      end
    end else begin
      m_streak = cur ? m_streak + 1 : 0;
      m_wait++;
      if (m_streak == STABLE_CYCLES) begin
        m_pulse = 1; m_step++; m_streak = 0; m_wait = 0; m_ooo = 0;
        if (m_step == m_steps) begin
          m_busy = 0; m_pass = 1;
        end
      end else if (m_tout != 0 && m_wait == m_tout) begin
        m_busy = 0; m_fail = 1; m_reason = 1;
      end else begin
`ifdef CHECKPOINT_SEQ_MONITOR_ORDER_CHECK_EN
        m_ooo = (later && !cur) ? m_ooo + 1 : 0;
        if (m_ooo == STABLE_CYCLES) begin
          m_busy = 0; m_fail = 1; m_reason = 2;
        end
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    model_edge();
    #1;
    if (match_pulse === 1'b1) n_pulses++;
    chk_eq("busy", busy, m_busy);
    chk_eq("pass", pass, m_pass);
    chk_eq("fail", fail, m_fail);
    chk_eq("fail_reason", fail_reason, m_reason);
    chk_eq("step_idx", step_idx, m_step);
    chk_eq("match_pulse", match_pulse, m_pulse);
    chk_eq("pass_fail_excl", pass & fail, 0);
  endtask

  task automatic load(input int idx, input logic [CHK_W-1:0] c, input logic [CHK_W-1:0] m);
    load_en = 1'b1; load_idx = idx[IDX_W-1:0]; load_code = c; load_mask = m;
    tick();
    load_en = 1'b0;
  endtask

  task automatic arm(input int n, input int t);
    num_steps = n[IDX_W:0]; timeout_cycles = t[TIMEOUT_W-1:0]; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive(input logic [CHK_W-1:0] v, input int n);
    chk_in = v;
    repeat (n) tick();
  endtask

  initial begin
    int n, hold, sel, s, r;
    logic [CHK_W-1:0] val, rnd;
    wb_rst_i = 1'b1; chk_in = 16'h0000; load_en = 1'b0; load_idx = 3'd0;
    load_code = 16'h0000; load_mask = 16'h0000; num_steps = 4'd0;
    timeout_cycles = 24'd0; start = 1'b0; abort = 1'b0;
    repeat (2) tick();
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_step", step_idx, 0);
    chk_eq("rst_reason", fail_reason, 0);
    wb_rst_i = 1'b0;

    // In-order sequence
    load(0, 16'hAB40, 16'hFFFF);
    load(1, 16'hAB41, 16'hFFFF);
    load(2, 16'hAB51, 16'hFFFF);
    n_pulses = 0;
    arm(3, 1000);
    drive(16'hAB40, 3);
    chk_eq("t1_step1", step_idx, 1);
    drive(16'hAB41, 3);
    chk_eq("t1_step2", step_idx, 2);
    drive(16'hAB51, 3);
    chk_eq("t1_step3", step_idx, 3);
    chk_eq("t1_pulses", n_pulses, 3);
    chk_eq("t1_pass", pass, 1);
    chk_eq("t1_fail", fail, 0);
    chk_eq("t1_busy", busy, 0);

    // Timeout exactly 1000 cycles after the first accept
    arm(3, 1000);
    drive(16'hAB40, 2);
    chk_eq("t2_accept", match_pulse, 1);
    chk_in = 16'h0000;
    n = 0;
    while (fail !== 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    chk_eq("t2_dist", n, 1000);
    chk_eq("t2_reason", fail_reason, 1);
    chk_eq("t2_step", step_idx, 1);

    // One-cycle glitch must not be accepted; two cycles must
    arm(3, 0);
    drive(16'hAB40, 2);
    drive(16'h0000, 1);
    drive(16'hAB41, 1);
    drive(16'h0000, 1);
    chk_eq("t3_glitch", step_idx, 1);
    drive(16'hAB41, 2);
    chk_eq("t3_hold", step_idx, 2);

    // Abort together with start
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk_eq("t4_abort_busy", busy, 0);
    chk_eq("t4_abort_pass", pass, 0);
    chk_eq("t4_abort_fail", fail, 0);
    tick();
    chk_eq("t4_idle_busy", busy, 0);

    // Masked compare
    load(0, 16'hAB00, 16'hFF00);
    arm(1, 0);
    drive(16'hAC00, 3);
    chk_eq("t5_nomatch", step_idx, 0);
    chk_eq("t5_busy", busy, 1);
    drive(16'hAB7F, 2);
    chk_eq("t5_pass", pass, 1);

    // Table write while running is dropped
    arm(1, 0);
    drive(16'h0000, 1);
    load(0, 16'h1234, 16'hFFFF);
    drive(16'hAB7F, 2);
    chk_eq("t6_wr_ignored", pass, 1);

    // Zero steps passes straight away
    arm(0, 5);
    chk_eq("t7_zero_pass", pass, 1);
    chk_eq("t7_zero_busy", busy, 0);

    // Later step's code while step 1 is expected
    load(0, 16'hAB40, 16'hFFFF);
    arm(3, 50);
    drive(16'hAB40, 2);
    drive(16'hAB51, 2);
`ifdef CHECKPOINT_SEQ_MONITOR_ORDER_CHECK_EN
    chk_eq("t8_ooo_fail", fail, 1);
    chk_eq("t8_ooo_reason", fail_reason, 2);
    chk_eq("t8_ooo_step", step_idx, 1);
`else
    chk_eq("t8_no_ooo", fail, 0);
    drive(16'h0000, 48);
    chk_eq("t8_tout_fail", fail, 1);
    chk_eq("t8_tout_reason", fail_reason, 1);
    chk_eq("t8_tout_step", step_idx, 1);
`endif

    // Randomized traffic
    hold = 0;
    val = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      start = (r < 6) || (r == 8);
      abort = (r == 6) || (r == 7) || (r == 8);
      wb_rst_i = ($urandom_range(0, 999) == 0);
      load_en = ($urandom_range(0, 9) == 0);
      load_idx = 3'($urandom_range(0, DEPTH - 1));
      rnd = 16'($urandom);
      load_code = {8'hAB, rnd[7:0]};
      load_mask = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
      num_steps = 4'($urandom_range(0, 15));
      timeout_cycles = 24'($urandom_range(0, 40));
      if (hold == 0) begin
        sel = $urandom_range(0, 9);
        s = (sel < 6) ? ((m_step < DEPTH) ? m_step : DEPTH - 1) : $urandom_range(0, DEPTH - 1);
        rnd = 16'($urandom);
        if (sel < 8) val = (m_code[s] & m_mask[s]) | (rnd & ~m_mask[s]);
        else val = rnd;
        hold = $urandom_range(1, 3);
      end
      chk_in = val;
      hold--;
      tick();
    end
    start = 1'b0; abort = 1'b0; load_en = 1'b0; wb_rst_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/checkpoint_seq_monitor.md
Name: checkpoint_seq_monitor

Overview:
- Synthesizable, parametrised checkpoint-sequence monitor for the user project area.
- Watches a CHK_W-bit status bus (typically the firmware checkbits on mprj_io[31:16]).
- Confirms that up to DEPTH programmed, masked codes appear in order, each within a programmable cycle budget.
- Reports pass/fail, the failing step and the failure reason, so firmware bring-up can be self-checked on silicon without a host bench.

Parameters:
- CHK_W, 16: width of monitored bus and of each code/mask.
- DEPTH, 8: number of sequence table entries (power of two, ≥2).
- IDX_W, 3: log2(DEPTH).
- TIMEOUT_W, 24: width of per-step timeout counter.
- STABLE_CYCLES, 2: consecutive matching samples needed to accept a step (1..15).

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- chk_in  in  CHK_W  monitored status bus
- load_en  in  1  write strobe for one table entry
- load_idx  in  IDX_W  table entry to write
- load_code  in  CHK_W  expected code
- load_mask  in  CHK_W  compare mask (1 = bit compared)
- num_steps  in  IDX_W+1  active steps, 0..DEPTH; sampled on start
- timeout_cycles  in  TIMEOUT_W  per-step budget, 0 = no timeout; sampled on start
- start  in  1  one-cycle pulse to arm the monitor
- abort  in  1  return to IDLE, no verdict
- busy  out  1  monitor running
- pass  out  1  sticky, all steps matched
- fail  out  1  sticky, sequence failed
- fail_reason  out  2  00 none, 01 timeout, 10 out-of-order
- step_idx  out  IDX_W+1  current or failing step
- match_pulse  out  1  one-cycle pulse on each accepted step

Behaviour:
- Reset: state IDLE; busy, pass, fail, match_pulse = 0; fail_reason = 00; step_idx = 0; timer and stable counter = 0; all codes = 0; all masks = all-ones.
- Table write: load_en writes code and mask at load_idx on the clock edge. The write is ignored while busy = 1. Out-of-range load_idx cannot occur (DEPTH is a power of two).
- States: IDLE, RUN, DONE_PASS, DONE_FAIL.
- IDLE → RUN on start:
  - Latch num_steps and timeout_cycles.
  - Clear pass, fail, fail_reason, step_idx, timer and stable counter.
  - If num_steps = 0, go directly to DONE_PASS with pass = 1 on the next edge.
  - num_steps > DEPTH is clamped to DEPTH.
- start in DONE_PASS or DONE_FAIL behaves as in IDLE: re-arm, clearing the verdict. start while in RUN is ignored.
- RUN, every edge:
  - Match condition: ((chk_in ^ code[step]) & mask[step]) == 0.
  - If the condition holds, the stable counter increments (saturating); otherwise it clears.
  - When the counter reaches STABLE_CYCLES: match_pulse = 1 for one cycle, step_idx increments, stable counter and timer clear.
  - The next step always needs fresh samples, even if its code equals the previous one.
  - If step_idx reaches num_steps: enter DONE_PASS, busy = 0, pass = 1.
- Timeout:
  - timer increments every RUN cycle and saturates at all-ones.
  - If timeout_cycles ≠ 0 and timer = timeout_cycles - 1 without an accept on that edge: enter DONE_FAIL, fail = 1, fail_reason = 01, step_idx frozen at the failing step.
  - If accept and timeout fall on the same edge, the accept wins.
- Latency: step accepted on the STABLE_CYCLES-th consecutive matching sampling edge; match_pulse is visible in the following cycle. busy = 1 from the edge after start until the verdict edge.
- abort (any state): next edge goes to IDLE with busy = 0. pass and fail are cleared, the table is kept. abort has priority over start and over any accept or timeout on the same edge.
- wb_rst_i mid-run: full reset as above, including the table.
- pass and fail are never both 1.

Optional Feature:
- Macro: CHECKPOINT_SEQ_MONITOR_ORDER_CHECK_EN.
- Enabled: while in RUN, if chk_in stably (STABLE_CYCLES samples) matches the masked code of any active step index > step_idx, and not the current step, enter DONE_FAIL with fail_reason = 10. step_idx reports the step that was expected.
- Disabled: only current-step matches are evaluated. fail_reason 10 is never produced, and the out-of-order comparator logic is not synthesized.

Test Plan:
- Load AB40, AB41, AB51 (mask FFFF); num_steps = 3, timeout = 1000. Drive each code for 3 cycles in order → three match_pulses, step_idx 1, 2, 3, then pass = 1, fail = 0, busy = 0.
- Same table; drive AB40 then hold 0000 → fail = 1, fail_reason = 01, step_idx = 1, exactly 1000 cycles after the first accept.
- STABLE_CYCLES = 2; glitch AB41 for 1 cycle between 0000 samples → no accept; hold it 2 cycles → accept.
- Mask FF00, code AB00; drive AB7F → accept. Drive AC00 → no accept.
- Mid-run abort with simultaneous start → IDLE, busy = 0, pass = fail = 0. A table write during RUN is ignored: readback behaviour is unchanged on re-run.
- ORDER_CHECK_EN defined: drive AB51 while step_idx = 1 → fail = 1, fail_reason = 10, step_idx = 1. Undefined → no fail until timeout.
